// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between the fetch and load/store ports; read data or store ack returns 2 cycles after accept.
// No accept-side stall: ready comes only from arbitration, the response pipeline never backpressures.
module sram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit DATA_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ready,
  output logic              inst_rvalid,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ready,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [31:0]       conflict_cnt
);

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef struct packed {
    logic vld;
    logic port;
    logic we;
  } stage_t;

  logic              grant_inst;
  logic              grant_data;
  logic              last_grant_q, last_grant_d;
  stage_t            s1_q, s1_d;
  stage_t            s2_q, s2_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic [31:0]       conflict_cnt_q, conflict_cnt_d;

  // Grants are masked while reset is asserted so every output reads 0 during reset.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (resetn) begin
      if (inst_req && data_req) begin
        if (DATA_PRIO || (last_grant_q == PORT_INST)) begin
          grant_data = 1'b1;
        end else begin
          grant_inst = 1'b1;
        end
      end else begin
        grant_inst = inst_req;
        grant_data = data_req;
      end
    end
  end

  always_comb begin
    inst_ready = grant_inst;
    data_ready = grant_data;
    sram_en    = grant_inst | grant_data;
    sram_we    = grant_data & data_we;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_inst) begin
      sram_addr = inst_addr;
    end else if (grant_data) begin
      sram_addr = data_addr;
    end
    if (grant_inst || grant_data) begin
      sram_wdata = data_wdata;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_inst) begin
      last_grant_d = PORT_INST;
    end else if (grant_data) begin
      last_grant_d = PORT_DATA;
    end

    s1_d.vld  = grant_inst | grant_data;
    s1_d.port = grant_data ? PORT_DATA : PORT_INST;
    s1_d.we   = grant_data & data_we;
    s2_d      = s1_q;

    // sram_rdata belongs to the read issued one cycle earlier, tracked by stage 1.
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    if (s1_q.vld && !s1_q.we) begin
      if (s1_q.port == PORT_INST) begin
        inst_rdata_d = sram_rdata;
      end else begin
        data_rdata_d = sram_rdata;
      end
    end

    conflict_cnt_d = conflict_cnt_q + {31'd0, inst_req & data_req};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q   <= PORT_DATA;
      s1_q           <= '0;
      s2_q           <= '0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign inst_rvalid  = s2_q.vld && (s2_q.port == PORT_INST);
  assign data_rvalid  = s2_q.vld && (s2_q.port == PORT_DATA);
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: round-robin and data-priority instances share one stimulus set and a TB SRAM model.
module tb_sram_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ready;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [31:0] conflict_cnt;

  logic        p1_inst_ready;
  logic        p1_inst_rvalid;
  logic [31:0] p1_inst_rdata;
  logic        p1_data_ready;
  logic        p1_data_rvalid;
  logic [31:0] p1_data_rdata;
  logic        p1_sram_en;
  logic        p1_sram_we;
  logic [31:0] p1_sram_addr;
  logic [31:0] p1_sram_wdata;
  logic [31:0] p1_conflict_cnt;

  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
  );

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1'b1)) dut_p1 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(p1_inst_ready),
    .inst_rvalid(p1_inst_rvalid), .inst_rdata(p1_inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(p1_data_ready), .data_rvalid(p1_data_rvalid), .data_rdata(p1_data_rdata),
    .sram_en(p1_sram_en), .sram_we(p1_sram_we), .sram_addr(p1_sram_addr), .sram_wdata(p1_sram_wdata),
    .sram_rdata(sram_rdata), .conflict_cnt(p1_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM model driven by the round-robin instance: synchronous write, 1-cycle read.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr[9:2]] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn   = 1'b0;
    inst_req = 1'b0;
    data_req = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_inst_ready"}, 64'(inst_ready), 64'd0);
    chk({tag, "_data_ready"}, 64'(data_ready), 64'd0);
    chk({tag, "_sram_en"}, 64'(sram_en), 64'd0);
    chk({tag, "_sram_we"}, 64'(sram_we), 64'd0);
    chk({tag, "_sram_addr"}, 64'(sram_addr), 64'd0);
    chk({tag, "_sram_wdata"}, 64'(sram_wdata), 64'd0);
    chk({tag, "_inst_rvalid"}, 64'(inst_rvalid), 64'd0);
    chk({tag, "_data_rvalid"}, 64'(data_rvalid), 64'd0);
    chk({tag, "_inst_rdata"}, 64'(inst_rdata), 64'd0);
    chk({tag, "_data_rdata"}, 64'(data_rdata), 64'd0);
    chk({tag, "_conflict_cnt"}, 64'(conflict_cnt), 64'd0);
    chk({tag, "_p1_ready"}, 64'({p1_inst_ready, p1_data_ready}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    mem[0]  <= 32'h0280_040c;
    mem[64] <= 32'h1111_2222;
    resetn     = 1'b0;
    inst_req   = 1'b1;
    data_req   = 1'b1;
    inst_addr  = 32'h1c00_0000;
    data_addr  = 32'h0000_0100;
    data_we    = 1'b0;
    data_wdata = 32'd0;
    #2;
    chk_all_zero("reset");
    do_reset();

    // Single fetch
    inst_req = 1'b1;
    #1;
    chk("fetch_inst_ready", 64'(inst_ready), 64'd1);
    chk("fetch_data_ready", 64'(data_ready), 64'd0);
    chk("fetch_sram_en", 64'(sram_en), 64'd1);
    chk("fetch_sram_we", 64'(sram_we), 64'd0);
    chk("fetch_sram_addr", 64'(sram_addr), 64'h1c00_0000);
    tick();
    inst_req = 1'b0;
    #1;
    chk("fetch_c1_rvalid", 64'(inst_rvalid), 64'd0);
    chk("idle_sram_en", 64'(sram_en), 64'd0);
    tick();
    chk("fetch_c2_rvalid", 64'(inst_rvalid), 64'd1);
    chk("fetch_c2_rdata", 64'(inst_rdata), 64'h0280_040c);
    chk("fetch_c2_data_rvalid", 64'(data_rvalid), 64'd0);
    tick();
    chk("fetch_c3_rvalid", 64'(inst_rvalid), 64'd0);
    chk("fetch_c3_rdata_held", 64'(inst_rdata), 64'h0280_040c);

    // Round-robin tie straight after reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      inst_req = (i < 4);
      data_req = (i < 4);
      #1;
      chk($sformatf("rr_c%0d_inst_ready", i), 64'(inst_ready), 64'((i == 0) || (i == 2)));
      chk($sformatf("rr_c%0d_data_ready", i), 64'(data_ready), 64'((i == 1) || (i == 3)));
      chk($sformatf("rr_c%0d_inst_rvalid", i), 64'(inst_rvalid), 64'((i == 2) || (i == 4)));
      chk($sformatf("rr_c%0d_data_rvalid", i), 64'(data_rvalid), 64'((i == 3) || (i == 5)));
      if (i == 2) chk("rr_inst_rdata", 64'(inst_rdata), 64'h0280_040c);
      if (i == 3) chk("rr_data_rdata", 64'(data_rdata), 64'h1111_2222);
      if (i >= 4) chk($sformatf("rr_c%0d_conflict_cnt", i), 64'(conflict_cnt), 64'd4);
      tick();
    end

    // Data-priority instance: data wins every tie
    for (int i = 0; i < 4; i++) begin
      inst_req = 1'b1;
      data_req = (i < 3);
      #1;
      chk($sformatf("prio_c%0d_data_ready", i), 64'(p1_data_ready), 64'(i < 3));
      chk($sformatf("prio_c%0d_inst_ready", i), 64'(p1_inst_ready), 64'(i == 3));
      tick();
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    tick();
    tick();
    tick();

    // Store then load to the same address
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 32'h0000_0100;
    data_wdata = 32'hdead_beef;
    #1;
    chk("st_data_ready", 64'(data_ready), 64'd1);
    chk("st_sram_we", 64'(sram_we), 64'd1);
    chk("st_sram_wdata", 64'(sram_wdata), 64'hdead_beef);
    tick();
    data_we    = 1'b0;
    data_wdata = 32'd0;
    #1;
    chk("ld_data_ready", 64'(data_ready), 64'd1);
    chk("ld_sram_we", 64'(sram_we), 64'd0);
    tick();
    data_req = 1'b0;
    #1;
    chk("st_ack_rvalid", 64'(data_rvalid), 64'd1);
    chk("st_ack_rdata_unchanged", 64'(data_rdata), 64'h1111_2222);
    tick();
    chk("ld_rvalid", 64'(data_rvalid), 64'd1);
    chk("ld_rdata", 64'(data_rdata), 64'hdead_beef);
    tick();
    chk("ld_rvalid_done", 64'(data_rvalid), 64'd0);

    // Reset while a fetch is in flight
    inst_req = 1'b1;
    #1;
    chk("mid_inst_ready", 64'(inst_ready), 64'd1);
    tick();
    data_req = 1'b1;
    resetn   = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    tick();
    inst_req = 1'b0;
    data_req = 1'b0;
    resetn   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mid_post_c%0d_inst_rvalid", i), 64'(inst_rvalid), 64'd0);
      tick();
    end
    inst_req = 1'b1;
    data_req = 1'b1;
    #1;
    chk("mid_tie_inst_ready", 64'(inst_ready), 64'd1);
    chk("mid_tie_data_ready", 64'(data_ready), 64'd0);
    tick();
    inst_req = 1'b0;
    data_req = 1'b0;

    // Conflict counter wrap
    force dut.conflict_cnt_q = 32'hffff_ffff;
    #1;
    chk("wrap_preload", 64'(conflict_cnt), 64'hffff_ffff);
    release dut.conflict_cnt_q;
    inst_req = 1'b1;
    data_req = 1'b1;
    tick();
    inst_req = 1'b0;
    data_req = 1'b0;
    #1;
    chk("wrap_conflict_cnt", 64'(conflict_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
